// File: rtl/branch_resolution_unit.sv
// EX-side branch resolution: prediction FIFO, mispredict redirect/flush, predictor training.
// Optional BRU_PERF_CNT_EN adds saturating br_count / mispred_count outputs.
module branch_resolution_unit #(
   parameter int DEPTH        = 4,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pred_push,
   input  logic [31:0]       pred_pc,
   input  logic              pred_used,
   input  logic [31:0]       pred_target,
   output logic              full,
   input  logic              resolve_valid,
   input  logic [31:0]       resolve_pc,
   input  logic              resolve_is_jump,
   input  logic              resolve_taken,
   input  logic [31:0]       resolve_target,
   output logic              redirect,
   output logic [31:0]       redirect_pc,
   output logic              flush,
   output logic              train_valid,
   output logic [31:0]       train_pc,
   output logic              train_taken,
   output logic [31:0]       train_target,
   output logic              train_is_jump
`ifdef BRU_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  br_count,
   output logic [CNT_W-1:0]  mispred_count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [AW:0]   FULL_CNT   = (AW+1)'(DEPTH);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

   typedef enum logic {S_IDLE, S_FLUSH} state_e;

   state_e        state_q, state_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [31:0]   pc_q  [DEPTH];
   logic [31:0]   tgt_q [DEPTH];
   logic          used_q[DEPTH];

   logic          redirect_q;
   logic [31:0]   redirect_pc_q;
   logic          tv_q, ttaken_q, tjump_q;
   logic [31:0]   tpc_q, ttgt_q;

   logic          idle, empty, matched, hit_used;
   logic          res_acc, mispred, pop, push;
   logic [31:0]   pc_plus4, pred_next, act_next;

   assign idle     = (state_q == S_IDLE);
   assign empty    = (cnt_q == '0);
   assign full     = (cnt_q == FULL_CNT);
   assign matched  = !empty && (pc_q[rd_q] == resolve_pc);
   assign hit_used = matched && used_q[rd_q];
   assign pc_plus4 = resolve_pc + 32'd4;
   assign pred_next = hit_used ? tgt_q[rd_q] : pc_plus4;
   assign act_next  = resolve_taken ? resolve_target : pc_plus4;
   assign res_acc  = resolve_valid && idle;
   assign mispred  = res_acc && (pred_next != act_next);
   assign pop      = res_acc && matched && !mispred;
   // a pop frees a slot in the same cycle, so a full FIFO still accepts
   assign push     = pred_push && idle && !mispred && (!full || pop);

   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (mispred) begin
               state_d = S_FLUSH;
               fcnt_d  = FLUSH_LAST;
            end
         end
         S_FLUSH: begin
            if (fcnt_q == '0) state_d = S_IDLE;
            else              fcnt_d  = fcnt_q - FW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (mispred) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         if (pop)  rd_d = rd_q + AW'(1);
         if (push) wr_d = wr_q + AW'(1);
         if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
         else if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         fcnt_q        <= '0;
         rd_q          <= '0;
         wr_q          <= '0;
         cnt_q         <= '0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         tv_q          <= 1'b0;
         tpc_q         <= '0;
         ttaken_q      <= 1'b0;
         ttgt_q        <= '0;
         tjump_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         fcnt_q     <= fcnt_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         cnt_q      <= cnt_d;
         redirect_q <= mispred;
         tv_q       <= res_acc;
         if (mispred) redirect_pc_q <= act_next;
         if (res_acc) begin
            tpc_q    <= resolve_pc;
            ttaken_q <= resolve_taken;
            ttgt_q   <= resolve_target;
            tjump_q  <= resolve_is_jump;
         end
      end
   end

   // storage needs no reset: occupancy is tracked by cnt_q
   always_ff @(posedge clk) begin
      if (push) begin
         pc_q[wr_q]   <= pred_pc;
         tgt_q[wr_q]  <= pred_target;
         used_q[wr_q] <= pred_used;
      end
   end

   assign redirect      = redirect_q;
   assign redirect_pc   = redirect_pc_q;
   assign flush         = (state_q == S_FLUSH);
   assign train_valid   = tv_q;
   assign train_pc      = tpc_q;
   assign train_taken   = ttaken_q;
   assign train_target  = ttgt_q;
   assign train_is_jump = tjump_q;

`ifdef BRU_PERF_CNT_EN
   logic [CNT_W-1:0] br_q, br_d, mis_q, mis_d;

   always_comb begin
      br_d  = br_q;
      mis_d = mis_q;
      if (res_acc && !(&br_q))  br_d  = br_q + CNT_W'(1);
      if (mispred && !(&mis_q)) mis_d = mis_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         br_q  <= '0;
         mis_q <= '0;
      end else begin
         br_q  <= br_d;
         mis_q <= mis_d;
      end
   end

   assign br_count      = br_q;
   assign mispred_count = mis_q;
`else
   localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Randomized bench for branch_resolution_unit against a queue-based reference model.
// Define BRU_PERF_CNT_EN on both files to cover the perf counters.
module tb_branch_resolution_unit;

   localparam int DEPTH        = 4;
   localparam int FLUSH_CYCLES = 2;
   localparam int CNT_W        = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        pred_push, pred_used;
   logic [31:0] pred_pc, pred_target;
   logic        full;
   logic        resolve_valid, resolve_is_jump, resolve_taken;
   logic [31:0] resolve_pc, resolve_target;
   logic        redirect, flush, train_valid, train_taken, train_is_jump;
   logic [31:0] redirect_pc, train_pc, train_target;
`ifdef BRU_PERF_CNT_EN
   logic [CNT_W-1:0] br_count, mispred_count;
`endif

   branch_resolution_unit #(
      .DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .pred_push(pred_push), .pred_pc(pred_pc),
      .pred_used(pred_used), .pred_target(pred_target),
      .full(full),
      .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
      .resolve_is_jump(resolve_is_jump), .resolve_taken(resolve_taken),
      .resolve_target(resolve_target),
      .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
      .train_valid(train_valid), .train_pc(train_pc),
      .train_taken(train_taken), .train_target(train_target),
      .train_is_jump(train_is_jump)
`ifdef BRU_PERF_CNT_EN
      , .br_count(br_count), .mispred_count(mispred_count)
`endif
   );

   typedef struct {
      logic [31:0] pc;
      logic        used;
      logic [31:0] tgt;
   } rec_t;

   rec_t q[$];
   int   flush_left;
   logic exp_full, exp_redirect, exp_flush, exp_tv, exp_ttaken, exp_tjump;
   logic [31:0] exp_rpc, exp_tpc, exp_ttgt;
   logic [CNT_W-1:0] exp_br, exp_mis;

   int n_cmp = 0;
   int n_fail = 0;
   bit chk_en = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit          mis, popped, matched, used;
      int          sz;
      logic [31:0] pn, an;
      rec_t        r;
      if (rst) begin
         q.delete();
         flush_left = 0;
         exp_redirect = 0; exp_rpc = 0;
         exp_tv = 0; exp_tpc = 0; exp_ttaken = 0; exp_ttgt = 0; exp_tjump = 0;
         exp_br = 0; exp_mis = 0;
      end else begin
         exp_redirect = 0;
         exp_tv = 0;
         if (flush_left > 0) begin
            flush_left--;
         end else begin
            mis = 0;
            popped = 0;
            sz = q.size();
            if (resolve_valid) begin
               matched = (sz > 0) && (q[0].pc == resolve_pc);
               used = matched && q[0].used;
               pn = used ? q[0].tgt : resolve_pc + 32'd4;
               an = resolve_taken ? resolve_target : resolve_pc + 32'd4;
               mis = (pn != an);
               exp_tv = 1; exp_tpc = resolve_pc; exp_ttaken = resolve_taken;
               exp_ttgt = resolve_target; exp_tjump = resolve_is_jump;
               if (exp_br != '1) exp_br++;
               if (mis) begin
                  q.delete();
                  flush_left = FLUSH_CYCLES;
                  exp_redirect = 1;
                  exp_rpc = an;
                  if (exp_mis != '1) exp_mis++;
               end else if (matched) begin
                  void'(q.pop_front());
                  popped = 1;
               end
            end
            if (pred_push && !mis && (sz < DEPTH || popped)) begin
               r.pc = pred_pc; r.used = pred_used; r.tgt = pred_target;
               q.push_back(r);
            end
         end
      end
      exp_flush = (flush_left > 0);
      exp_full  = (q.size() == DEPTH);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("full", 32'(full), 32'(exp_full));
         chk("redirect", 32'(redirect), 32'(exp_redirect));
         chk("redirect_pc", redirect_pc, exp_rpc);
         chk("flush", 32'(flush), 32'(exp_flush));
         chk("train_valid", 32'(train_valid), 32'(exp_tv));
         chk("train_pc", train_pc, exp_tpc);
         chk("train_taken", 32'(train_taken), 32'(exp_ttaken));
         chk("train_target", train_target, exp_ttgt);
         chk("train_is_jump", 32'(train_is_jump), 32'(exp_tjump));
`ifdef BRU_PERF_CNT_EN
         chk("br_count", 32'(br_count), 32'(exp_br));
         chk("mispred_count", 32'(mispred_count), 32'(exp_mis));
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic nop();
      pred_push = 0; pred_pc = 0; pred_used = 0; pred_target = 0;
      resolve_valid = 0; resolve_pc = 0; resolve_is_jump = 0;
      resolve_taken = 0; resolve_target = 0;
   endtask

   task automatic push(logic [31:0] pc, logic used, logic [31:0] tgt);
      pred_push = 1; pred_pc = pc; pred_used = used; pred_target = tgt;
   endtask

   task automatic resolve(logic [31:0] pc, logic taken, logic [31:0] tgt);
      resolve_valid = 1; resolve_pc = pc; resolve_is_jump = 0;
      resolve_taken = taken; resolve_target = tgt;
   endtask

   initial begin
      nop();
      rst = 1;
      step();
      chk_en = 1;
      step();
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'd0);
      rst = 0;

      // correct prediction
      push(32'h100, 1, 32'h200); step(); nop();
      resolve(32'h100, 1, 32'h200); step(); nop();
      chk("t1_train_valid", 32'(train_valid), 32'd1);
      chk("t1_train_pc", train_pc, 32'h100);
      chk("t1_train_tgt", train_target, 32'h200);
      chk("t1_redirect", 32'(redirect), 32'd0);
      chk("t1_flush", 32'(flush), 32'd0);
      step();

      // unpredicted taken branch
      push(32'h100, 0, 32'h0); step(); nop();
      resolve(32'h100, 1, 32'h180); step(); nop();
      chk("t2_redirect", 32'(redirect), 32'd1);
      chk("t2_redirect_pc", redirect_pc, 32'h180);
      chk("t2_flush1", 32'(flush), 32'd1);
      step();
      chk("t2_redirect_off", 32'(redirect), 32'd0);
      chk("t2_flush2", 32'(flush), 32'd1);
      step();
      chk("t2_flush_end", 32'(flush), 32'd0);

      // predicted taken, actually not taken; pushes during flush dropped
      push(32'h100, 1, 32'h200); step(); nop();
      resolve(32'h100, 0, 32'h200); step(); nop();
      chk("t3_redirect_pc", redirect_pc, 32'h104);
      push(32'h300, 0, 32'h0); step(); step(); nop();
      step();
      chk("t3_full", 32'(full), 32'd0);

      // fill, overflow, push+pop while full, drain
      for (int i = 0; i < DEPTH; i++) begin
         push(32'h10 + 32'(4*i), 0, 32'h0); step();
      end
      nop();
      chk("t4_full", 32'(full), 32'd1);
      push(32'h20, 0, 32'h0); step(); nop();
      chk("t4_full_drop", 32'(full), 32'd1);
      push(32'h24, 0, 32'h0); resolve(32'h10, 0, 32'h0); step(); nop();
      chk("t4_full_pushpop", 32'(full), 32'd1);
      chk("t4_no_redirect", 32'(redirect), 32'd0);
      resolve(32'h14, 0, 32'h0); step();
      resolve(32'h18, 0, 32'h0); step();
      resolve(32'h1c, 0, 32'h0); step();
      resolve(32'h24, 0, 32'h0); step(); nop();
      chk("t4_drained", 32'(full), 32'd0);
      chk("t4_no_flush", 32'(flush), 32'd0);
      // if 0x20 had been queued, this resolve would match it and pop
      resolve(32'h20, 0, 32'h0); step(); nop();
      chk("t4_empty", 32'(flush), 32'd0);

      // pc+4 wraps, empty FIFO
      resolve(32'hFFFF_FFFC, 0, 32'h0); step(); nop();
      chk("t5_train_valid", 32'(train_valid), 32'd1);
      chk("t5_train_pc", train_pc, 32'hFFFF_FFFC);
      chk("t5_redirect", 32'(redirect), 32'd0);
      chk("t5_flush", 32'(flush), 32'd0);

      // reset during first flush cycle
      push(32'h40, 0, 32'h0); step(); nop();
      resolve(32'h40, 1, 32'h80); step(); nop();
      chk("t6_flush", 32'(flush), 32'd1);
      rst = 1; step(); rst = 0;
      chk("t6_flush_rst", 32'(flush), 32'd0);
      chk("t6_full_rst", 32'(full), 32'd0);
`ifdef BRU_PERF_CNT_EN
      chk("t6_br_rst", 32'(br_count), 32'd0);
      chk("t6_mis_rst", 32'(mispred_count), 32'd0);
`endif

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         nop();
         rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 1) == 1)
            push(32'h1000 + 32'($urandom_range(0, 15) * 4),
                 1'($urandom_range(0, 1)),
                 32'h2000 + 32'($urandom_range(0, 3) * 4));
         if ($urandom_range(0, 2) == 0) begin
            resolve_valid = 1;
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
               resolve_pc = q[0].pc;
            else if ($urandom_range(0, 7) == 0)
               resolve_pc = 32'hFFFF_FFFC;
            else
               resolve_pc = 32'h1000 + 32'($urandom_range(0, 15) * 4);
            resolve_is_jump = ($urandom_range(0, 5) == 0);
            resolve_taken = resolve_is_jump || ($urandom_range(0, 1) == 1);
            if (q.size() > 0 && $urandom_range(0, 1) == 1)
               resolve_target = q[0].tgt;
            else
               resolve_target = 32'h2000 + 32'($urandom_range(0, 3) * 4);
         end
         step();
      end
      nop();
      rst = 0;
      step();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
